// File: rtl/heap_pq_engine_pkg.sv
// Shared encodings and ordering helper for the heap priority-queue engine.
package heap_pq_pkg;

  localparam logic [2:0] CMD_BUILD   = 3'b000;
  localparam logic [2:0] CMD_EXTRACT = 3'b001;
  localparam logic [2:0] CMD_PROMOTE = 3'b010;
  localparam logic [2:0] CMD_INSERT  = 3'b011;
  localparam logic [2:0] CMD_WRITE   = 3'b100;
  localparam logic [2:0] CMD_CLEAR   = 3'b101;

  localparam logic [1:0] SEL_NODE  = 2'd0;
  localparam logic [1:0] SEL_LEFT  = 2'd1;
  localparam logic [1:0] SEL_RIGHT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_BUILD,
    S_SIFT_DOWN,
    S_SIFT_UP,
    S_WRITE
  } state_e;

  // True when a is strictly better than b (unsigned; callers zero-extend).
  function automatic logic better(input logic [63:0] a, input logic [63:0] b,
                                  input logic min_heap);
    return min_heap ? (a < b) : (a > b);
  endfunction

endpackage

// File: rtl/heap_pq_engine_if.sv
// Stream-load, command, result and RAM write-out signals of the heap engine.
interface heap_pq_engine_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              data_valid;
  logic [DATA_W-1:0] data;
  logic              cmd_valid;
  logic [2:0]        cmd;
  logic [ADDR_W-1:0] index;
  logic [DATA_W-1:0] value;
  logic              busy;
  logic              top_valid;
  logic [DATA_W-1:0] top_data;
  logic              RAM_valid;
  logic [ADDR_W-1:0] RAM_A;
  logic [DATA_W-1:0] RAM_D;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   count;

  modport master (
    output data_valid, data, cmd_valid, cmd, index, value,
    input  busy, top_valid, top_data, RAM_valid, RAM_A, RAM_D, done, err, count
  );

  modport slave (
    input  data_valid, data, cmd_valid, cmd, index, value,
    output busy, top_valid, top_data, RAM_valid, RAM_A, RAM_D, done, err, count
  );
endinterface

// File: rtl/heap_pq_engine_cmp_sel.sv
// Combinational better-of-three selector; a child only wins when strictly better.
module heap_cmp_sel
  import heap_pq_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int MIN_HEAP = 0
) (
  input  logic [DATA_W-1:0] node_d,
  input  logic [DATA_W-1:0] left_d,
  input  logic [DATA_W-1:0] right_d,
  input  logic              left_ok,
  input  logic              right_ok,
  output logic [1:0]        sel
);
  localparam logic MINH = (MIN_HEAP != 0);

  logic [DATA_W-1:0] best;

  always_comb begin
    sel  = SEL_NODE;
    best = node_d;
    if (left_ok && better(64'(left_d), 64'(best), MINH)) begin
      sel  = SEL_LEFT;
      best = left_d;
    end
    if (right_ok && better(64'(right_d), 64'(best), MINH)) begin
      sel  = SEL_RIGHT;
      best = right_d;
    end
  end
endmodule

// File: rtl/heap_pq_engine.sv
// Binary-heap priority queue: stream load, build, extract, promote, insert,
// clear and RAM write-out over an internal register array.
module heap_pq_engine
  import heap_pq_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int MIN_HEAP = 0
) (
  input logic             clk,
  input logic             rst,
  heap_pq_engine_if.slave bus
);
  localparam int CW = ADDR_W + 1;
  localparam int XW = ADDR_W + 2;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [XW-1:0] DEPTH_X = XW'(DEPTH);
  localparam logic          MINH    = (MIN_HEAP != 0);

  state_e state, state_n;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [CW-1:0] cnt, cur, bld_i, wr_idx;
  logic          in_build, err_q;

  logic [XW-1:0]     lc, rc;
  logic [CW-1:0]     pc, last;
  logic [ADDR_W-1:0] cur_a, lc_a, rc_a, pc_a, wr_a, cnt_a, last_a, idx_a, win_a;
  logic              left_ok, right_ok, up_swap, sd_swap, idle_cmd, cmd_ok;
  logic [1:0]        sel;

  function automatic logic [ADDR_W-1:0] aidx(input logic [XW-1:0] i);
    return (i < DEPTH_X) ? i[ADDR_W-1:0] : '0;
  endfunction

  // Child indices carry an extra bit so 2i+2 of the last leaf cannot wrap.
  always_comb begin
    lc       = {cur, 1'b1};
    rc       = lc + XW'(1);
    pc       = (cur - CW'(1)) >> 1;
    last     = cnt - CW'(1);
    cur_a    = aidx({1'b0, cur});
    lc_a     = aidx(lc);
    rc_a     = aidx(rc);
    pc_a     = aidx({1'b0, pc});
    wr_a     = aidx({1'b0, wr_idx});
    cnt_a    = aidx({1'b0, cnt});
    last_a   = aidx({1'b0, last});
    idx_a    = aidx(XW'(bus.index));
    left_ok  = lc < {1'b0, cnt};
    right_ok = rc < {1'b0, cnt};
    up_swap  = (cur != '0) && better(64'(mem[cur_a]), 64'(mem[pc_a]), MINH);
    sd_swap  = (sel != SEL_NODE);
    win_a    = (sel == SEL_RIGHT) ? rc_a : lc_a;
    idle_cmd = (state == S_IDLE) && !bus.data_valid && bus.cmd_valid;
    cmd_ok   = 1'b0;
    case (bus.cmd)
      CMD_BUILD, CMD_WRITE, CMD_CLEAR: cmd_ok = 1'b1;
      CMD_EXTRACT: cmd_ok = (cnt != '0);
      CMD_PROMOTE: cmd_ok = (CW'(bus.index) < cnt) &&
                            !better(64'(mem[idx_a]), 64'(bus.value), MINH);
      CMD_INSERT:  cmd_ok = (cnt != FULL);
      default:     cmd_ok = 1'b0;
    endcase
  end

  heap_cmp_sel #(
    .DATA_W  (DATA_W),
    .MIN_HEAP(MIN_HEAP)
  ) u_cmp (
    .node_d  (mem[cur_a]),
    .left_d  (mem[lc_a]),
    .right_d (mem[rc_a]),
    .left_ok (left_ok),
    .right_ok(right_ok),
    .sel     (sel)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    bus.busy      = (state != S_IDLE) && (state != S_LOAD);
    bus.top_valid = 1'b0;
    bus.top_data  = '0;
    bus.RAM_valid = 1'b0;
    bus.RAM_A     = '0;
    bus.RAM_D     = '0;
    bus.done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.data_valid) begin
          state_n = S_LOAD;
        end else if (idle_cmd && cmd_ok) begin
          case (bus.cmd)
            CMD_BUILD: state_n = S_BUILD;
            CMD_EXTRACT: begin
              state_n       = S_SIFT_DOWN;
              bus.top_valid = 1'b1;
              bus.top_data  = mem[0];
            end
            CMD_PROMOTE, CMD_INSERT: state_n = S_SIFT_UP;
            CMD_WRITE: state_n = S_WRITE;
            default: ;
          endcase
        end
      end
      S_LOAD:      if (!bus.data_valid) state_n = S_IDLE;
      S_BUILD:     state_n = (cnt > CW'(1)) ? S_SIFT_DOWN : S_IDLE;
      S_SIFT_DOWN: if (!sd_swap && !(in_build && bld_i != '0)) state_n = S_IDLE;
      S_SIFT_UP:   if (!up_swap) state_n = S_IDLE;
      S_WRITE: begin
        if (wr_idx != cnt) begin
          bus.RAM_valid = 1'b1;
          bus.RAM_A     = wr_a;
          bus.RAM_D     = mem[wr_a];
        end else begin
          bus.done = 1'b1;
          state_n  = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      cur      <= '0;
      bld_i    <= '0;
      wr_idx   <= '0;
      in_build <= 1'b0;
      err_q    <= 1'b0;
      for (int unsigned k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      err_q <= 1'b0;
      case (state)
        S_IDLE, S_LOAD: begin
          if (bus.data_valid) begin
            if (cnt == FULL) begin
              err_q <= 1'b1;
            end else begin
              mem[cnt_a] <= bus.data;
              cnt        <= cnt + CW'(1);
            end
          end else if (idle_cmd) begin
            if (!cmd_ok) begin
              err_q <= 1'b1;
            end else begin
              case (bus.cmd)
                CMD_EXTRACT: begin
                  mem[0]   <= mem[last_a];
                  cnt      <= last;
                  cur      <= '0;
                  in_build <= 1'b0;
                end
                CMD_PROMOTE: begin
                  mem[idx_a] <= bus.value;
                  cur        <= CW'(bus.index);
                end
                CMD_INSERT: begin
                  mem[cnt_a] <= bus.value;
                  cnt        <= cnt + CW'(1);
                  cur        <= cnt;
                end
                CMD_WRITE: wr_idx <= '0;
                CMD_CLEAR: cnt    <= '0;
                default: ;
              endcase
            end
          end
        end
        S_BUILD: begin
          if (cnt > CW'(1)) begin
            cur      <= (cnt >> 1) - CW'(1);
            bld_i    <= (cnt >> 1) - CW'(1);
            in_build <= 1'b1;
          end
        end
        S_SIFT_DOWN: begin
          if (sd_swap) begin
            mem[cur_a] <= mem[win_a];
            mem[win_a] <= mem[cur_a];
            cur        <= (sel == SEL_RIGHT) ? rc[CW-1:0] : lc[CW-1:0];
          end else if (in_build && bld_i != '0) begin
            // Build moves straight to the next lower internal node without an idle hop.
            bld_i <= bld_i - CW'(1);
            cur   <= bld_i - CW'(1);
          end else begin
            in_build <= 1'b0;
          end
        end
        S_SIFT_UP: begin
          if (up_swap) begin
            mem[cur_a] <= mem[pc_a];
            mem[pc_a]  <= mem[cur_a];
            cur        <= pc;
          end
        end
        S_WRITE: if (wr_idx != cnt) wr_idx <= wr_idx + CW'(1);
        default: ;
      endcase
    end
  end

  assign bus.err   = err_q;
  assign bus.count = cnt;
endmodule

// File: tb/tb_heap_pq_engine.sv
// Directed bench for heap_pq_engine: max-heap and min-heap instances share stimulus.
module tb_heap_pq_engine;
  import heap_pq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       dv_i, cv_i;
  logic [7:0] d_i, val_i;
  logic [2:0] cmd_i;
  logic [4:0] idx_i;
  logic       use_min;
  int         checks = 0;
  int         errors = 0;
  logic       tv_s;
  logic [7:0] td_s;

  heap_pq_engine_if #(.DATA_W(8), .ADDR_W(5)) bm ();
  heap_pq_engine_if #(.DATA_W(8), .ADDR_W(5)) bn ();

  assign bm.data_valid = dv_i;
  assign bm.data       = d_i;
  assign bm.cmd_valid  = cv_i;
  assign bm.cmd        = cmd_i;
  assign bm.index      = idx_i;
  assign bm.value      = val_i;
  assign bn.data_valid = dv_i;
  assign bn.data       = d_i;
  assign bn.cmd_valid  = cv_i;
  assign bn.cmd        = cmd_i;
  assign bn.index      = idx_i;
  assign bn.value      = val_i;

  heap_pq_engine #(.DATA_W(8), .DEPTH(32), .ADDR_W(5), .MIN_HEAP(0)) dut_max (
    .clk(clk), .rst(rst), .bus(bm)
  );
  heap_pq_engine #(.DATA_W(8), .DEPTH(32), .ADDR_W(5), .MIN_HEAP(1)) dut_min (
    .clk(clk), .rst(rst), .bus(bn)
  );

  logic       o_busy, o_tv, o_rv, o_done, o_err;
  logic [7:0] o_td, o_rd;
  logic [4:0] o_ra;
  logic [5:0] o_count;
  assign o_busy  = use_min ? bn.busy      : bm.busy;
  assign o_tv    = use_min ? bn.top_valid : bm.top_valid;
  assign o_td    = use_min ? bn.top_data  : bm.top_data;
  assign o_rv    = use_min ? bn.RAM_valid : bm.RAM_valid;
  assign o_ra    = use_min ? bn.RAM_A     : bm.RAM_A;
  assign o_rd    = use_min ? bn.RAM_D     : bm.RAM_D;
  assign o_done  = use_min ? bn.done      : bm.done;
  assign o_err   = use_min ? bn.err       : bm.err;
  assign o_count = use_min ? bn.count     : bm.count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    dv_i = 1'b1;
    d_i  = d;
    @(negedge clk);
  endtask

  task automatic dv_off();
    dv_i = 1'b0;
    @(negedge clk);
  endtask

  // Presents one command for one cycle; top_valid/top_data are captured in that cycle.
  task automatic issue(input logic [2:0] c, input logic [4:0] ix, input logic [7:0] v);
    cmd_i = c;
    idx_i = ix;
    val_i = v;
    cv_i  = 1'b1;
    #1;
    tv_s = o_tv;
    td_s = o_td;
    @(negedge clk);
    cv_i = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int n = 0;
    while (o_busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(o_busy), 0);
  endtask

  task automatic write_check(input int n, input logic [7:0] ex [8], input string tag);
    int beats = 0;
    bit got_done = 1'b0;
    issue(CMD_WRITE, 5'd0, 8'd0);
    for (int t = 0; t < n + 4 && !got_done; t++) begin
      if (o_rv) begin
        chk({tag, "_addr"}, 32'(o_ra), beats);
        if (beats < 8) chk({tag, "_data"}, 32'(o_rd), 32'(ex[beats]));
        beats++;
      end else if (o_done) begin
        got_done = 1'b1;
      end
      if (!got_done) @(negedge clk);
    end
    chk({tag, "_beats"}, beats, n);
    chk({tag, "_done"}, 32'(got_done), 1);
    @(negedge clk);
    wait_idle(4, {tag, "_idle"});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ex [8];
    int nerr;
    int beats;
    rst = 1'b1; dv_i = 1'b0; cv_i = 1'b0; d_i = '0; val_i = '0;
    cmd_i = '0; idx_i = '0; use_min = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy",  32'(o_busy),  0);
    chk("rst_count", 32'(o_count), 0);
    chk("rst_err",   32'(o_err),   0);
    chk("rst_ramv",  32'(o_rv),    0);
    chk("rst_done",  32'(o_done),  0);
    chk("rst_topv",  32'(o_tv),    0);
    rst = 1'b0;
    @(negedge clk);

    // Max-heap build and write-out
    push(3); push(7); push(1); push(9); push(5);
    chk("load_busy", 32'(o_busy), 0);
    dv_off();
    chk("load_count", 32'(o_count), 5);
    issue(CMD_BUILD, 5'd0, 8'd0);
    chk("build_busy", 32'(o_busy), 1);
    wait_idle(100, "build_idle");
    ex = '{8'd9, 8'd7, 8'd1, 8'd3, 8'd5, 8'd0, 8'd0, 8'd0};
    write_check(5, ex, "wr_build");
    chk("build_count", 32'(o_count), 5);

    // Extract then insert
    issue(CMD_EXTRACT, 5'd0, 8'd0);
    chk("ext_topv", 32'(tv_s), 1);
    chk("ext_topd", 32'(td_s), 9);
    chk("ext_count", 32'(o_count), 4);
    wait_idle(6, "ext_idle");
    ex = '{8'd7, 8'd5, 8'd1, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0};
    write_check(4, ex, "wr_ext");
    issue(CMD_INSERT, 5'd0, 8'd8);
    chk("ins_count", 32'(o_count), 5);
    chk("ins_err", 32'(o_err), 0);
    wait_idle(5, "ins_idle");
    ex = '{8'd8, 8'd7, 8'd1, 8'd3, 8'd5, 8'd0, 8'd0, 8'd0};
    write_check(5, ex, "wr_ins");

    // Promote: legal, worse value, out of range, equal value
    issue(CMD_PROMOTE, 5'd2, 8'd10);
    chk("prom_ok_err", 32'(o_err), 0);
    wait_idle(5, "prom_idle");
    issue(CMD_PROMOTE, 5'd1, 8'd2);
    chk("prom_worse_err", 32'(o_err), 1);
    chk("prom_worse_busy", 32'(o_busy), 0);
    issue(CMD_PROMOTE, 5'd5, 8'd50);
    chk("prom_range_err", 32'(o_err), 1);
    issue(CMD_PROMOTE, 5'd4, 8'd5);
    chk("prom_equal_err", 32'(o_err), 0);
    wait_idle(5, "prom_eq_idle");
    ex = '{8'd10, 8'd7, 8'd8, 8'd3, 8'd5, 8'd0, 8'd0, 8'd0};
    write_check(5, ex, "wr_prom");

    // Min-heap instance
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    use_min = 1'b1;
    push(3); push(7); push(1); push(9); push(5);
    dv_off();
    issue(CMD_BUILD, 5'd0, 8'd0);
    wait_idle(100, "min_build_idle");
    ex = '{8'd1, 8'd5, 8'd3, 8'd9, 8'd7, 8'd0, 8'd0, 8'd0};
    write_check(5, ex, "min_wr");
    issue(CMD_EXTRACT, 5'd0, 8'd0);
    chk("min_ext_topv", 32'(tv_s), 1);
    chk("min_ext_topd", 32'(td_s), 1);
    wait_idle(6, "min_ext_idle");
    use_min = 1'b0;

    // Boundaries
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
    issue(CMD_EXTRACT, 5'd0, 8'd0);
    chk("empty_topv", 32'(tv_s), 0);
    chk("empty_err", 32'(o_err), 1);
    chk("empty_count", 32'(o_count), 0);
    @(negedge clk);
    chk("empty_err_pulse", 32'(o_err), 0);

    nerr = 0;
    for (int k = 0; k < 34; k++) begin
      push(8'(k));
      if (o_err) nerr++;
    end
    dv_off();
    if (o_err) nerr++;
    chk("over_errs", nerr, 2);
    chk("over_count", 32'(o_count), 32);
    issue(CMD_INSERT, 5'd0, 8'd200);
    chk("full_ins_err", 32'(o_err), 1);
    chk("full_ins_count", 32'(o_count), 32);
    issue(3'b111, 5'd0, 8'd0);
    chk("rsv7_err", 32'(o_err), 1);
    issue(3'b110, 5'd0, 8'd0);
    chk("rsv6_err", 32'(o_err), 1);

    issue(CMD_BUILD, 5'd0, 8'd0);
    chk("big_build_busy", 32'(o_busy), 1);
    issue(3'b111, 5'd0, 8'd0);
    chk("busy_ignore_err", 32'(o_err), 0);
    chk("busy_ignore_busy", 32'(o_busy), 1);
    wait_idle(300, "big_build_idle");
    issue(CMD_EXTRACT, 5'd0, 8'd0);
    chk("big_ext_topd", 32'(td_s), 31);
    chk("big_ext_count", 32'(o_count), 31);
    wait_idle(6, "big_ext_idle");

    issue(CMD_CLEAR, 5'd0, 8'd0);
    chk("clear_count", 32'(o_count), 0);
    chk("clear_busy", 32'(o_busy), 0);
    write_check(0, ex, "wr_empty");

    // Reset during write-out
    push(3); push(7); push(1); push(9); push(5);
    dv_off();
    cmd_i = CMD_WRITE; cv_i = 1'b1;
    @(negedge clk);
    cv_i = 1'b0;
    chk("rw_b0_valid", 32'(o_rv), 1);
    chk("rw_b0_addr", 32'(o_ra), 0);
    chk("rw_b0_data", 32'(o_rd), 3);
    @(negedge clk);
    chk("rw_b1_addr", 32'(o_ra), 1);
    chk("rw_b1_data", 32'(o_rd), 7);
    rst = 1'b1;
    #1;
    chk("rw_rst_ramv", 32'(o_rv), 0);
    chk("rw_rst_rama", 32'(o_ra), 0);
    chk("rw_rst_ramd", 32'(o_rd), 0);
    chk("rw_rst_busy", 32'(o_busy), 0);
    chk("rw_rst_done", 32'(o_done), 0);
    chk("rw_rst_count", 32'(o_count), 0);
    @(negedge clk);
    rst = 1'b0;
    beats = 0;
    repeat (4) begin
      @(negedge clk);
      if (o_rv || o_done) beats++;
    end
    chk("rw_no_resume", beats, 0);
    chk("rw_count_after", 32'(o_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/heap_pq_engine.md
Name: heap_pq_engine

Overview:
Parametrised binary-heap priority queue with a configurable element width, depth and max/min ordering. Elements load by streaming, a build command heapifies them, and single-element operations (extract, promote, insert, clear) run in O(log n) cycles using sift-down or sift-up. The heap image streams to external RAM on a write-out command. Error flags cover every illegal operation.

Parameters:
DATA_W, 8, element width in bits
DEPTH, 32, maximum number of elements (≥2)
ADDR_W, $clog2(DEPTH), element index width
MIN_HEAP, 0, 0 = max-heap, 1 = min-heap; "better" means greater when 0, smaller when 1

Ports:
clk  in  1  clock
rst  in  1  reset
data_valid  in  1  stream-load strobe
data  in  DATA_W  stream-load element
cmd_valid  in  1  command strobe
cmd  in  3  000 build, 001 extract, 010 promote, 011 insert, 100 write-out, 101 clear; 110/111 reserved
index  in  ADDR_W  promote target index
value  in  DATA_W  promote/insert value
busy  out  1  high while a command executes
top_valid  out  1  one-cycle pulse carrying the extracted element
top_data  out  DATA_W  extracted element
RAM_valid  out  1  write-out strobe
RAM_A  out  ADDR_W  write-out address
RAM_D  out  DATA_W  write-out data
done  out  1  one-cycle pulse at write-out completion
err  out  1  one-cycle pulse on an illegal command or overflow
count  out  ADDR_W+1  current element count

Behaviour:
- Single clock clk. Reset rst is asynchronous and active-high.
- Reset: all outputs 0, count 0, storage cleared, state IDLE. Reset asserted mid-operation aborts immediately; no partial RAM burst continues after reset.
- States: IDLE, LOAD, BUILD, SIFT_DOWN, SIFT_UP, WRITE.
- IDLE: data_valid has priority over cmd_valid in the same cycle. cmd_valid is sampled only in IDLE; commands presented while busy are ignored with no err.
- LOAD:
  - Each data_valid cycle stores data at index count and increments count.
  - When count==DEPTH, further elements are dropped and err pulses once per dropped element.
  - Returns to IDLE on the first cycle with data_valid low. busy stays 0 during LOAD.
- BUILD: i starts at count/2−1 and counts down to 0; each i runs SIFT_DOWN from i. If count≤1, return to IDLE the next cycle.
- SIFT_DOWN: one cycle per level.
  - Compare node with its children that lie below count; swap with the better child if it is strictly better, then continue at that child; otherwise finish.
  - Ties do not swap.
- SIFT_UP: one cycle per level. Swap with parent while strictly better; stop at index 0.
- extract:
  - If count==0: err pulse, no change.
  - Otherwise top_valid=1 with top_data=old root in the accept cycle, move the last element to the root, count−1, then SIFT_DOWN from 0.
- promote:
  - err and no change if index≥count, or if value is not better than or equal to the current element.
  - Otherwise write value and SIFT_UP from index.
- insert:
  - If count==DEPTH: err, no change.
  - Otherwise write value at count, count+1, SIFT_UP from the new index.
- write-out:
  - For count cycles: RAM_valid=1, RAM_A=0..count−1, RAM_D=element.
  - The next cycle: RAM_valid=0, done=1 for one cycle, return to IDLE.
  - With count==0, done pulses the cycle after accept.
- clear: count←0 in one cycle; storage contents are don't-care.
- Reserved cmd codes: err pulse, no change.
- busy: rises the cycle after accept and falls on the cycle the FSM re-enters IDLE. Every err pulse appears the cycle after accept.
- Arithmetic: indices are ADDR_W+1 bits wide so child index 2i+2 never wraps. Compare is unsigned.
- Latencies: insert/promote ≤ 1+⌈log2 DEPTH⌉ cycles; extract ≤ 2+⌈log2 DEPTH⌉ cycles.

Decomposition:
- Package heap_pq_pkg holds the cmd encodings, state enum, and a better(a,b,MIN_HEAP) function.
- One sub-module, heap_cmp_sel: a combinational 3-way better-of selector (node, left, right, valid flags) returning the winner index. It is reused by BUILD and SIFT_DOWN.
- Storage is an internal register array.

Test Plan:
- Max-heap build: load 3,7,1,9,5; build; write-out → RAM_D 9,7,1,3,5 at A 0..4; done pulse; count=5.
- Extract, then insert: extract → top_data=9, heap 7,5,1,3; insert 8 → write-out gives 8,7,1,3,5.
- Promote: from 8,7,1,3,5, promote index=2 value=10 → 10,7,8,3,5. Promote index=1 value=2 → err, heap unchanged. Promote index=5 → err.
- MIN_HEAP=1: load 3,7,1,9,5; build; write-out → 1,5,3,9,7. Extract → top_data=1.
- Boundaries: extract on empty → err, count 0. Load DEPTH+2 elements → two err pulses, count=DEPTH. Insert when full → err. Cmd 111 → err.
- Reset mid write-out (after 2 RAM beats) → all outputs 0 next edge, count=0. cmd_valid while busy → ignored.
